// File: rtl/yrow_read_extract_if.sv
// Request, Y-memory read and response signals of the Y-row read/extract block.
// slave is the block itself; master is whoever drives requests, memory data and rsp_ready.
interface yrow_read_extract_if #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned ROW_W   = 256,
    parameter int unsigned ENTRY_W = 48
);
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_diag_addr;
    logic [ADDR_W-1:0]  req_nondiag_addr;
    logic [3:0]         req_diag_oh;
    logic [3:0]         req_nondiag_oh;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_rd_addr;
    logic [ROW_W-1:0]   mem_rd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ENTRY_W-1:0] rsp_diag_val;
    logic [ENTRY_W-1:0] rsp_nondiag_val;
    logic               rsp_err;

    modport master (
        output req_valid, req_diag_addr, req_nondiag_addr, req_diag_oh, req_nondiag_oh,
        input  req_ready,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  rsp_valid, rsp_diag_val, rsp_nondiag_val, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_diag_addr, req_nondiag_addr, req_diag_oh, req_nondiag_oh,
        output req_ready,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output rsp_valid, rsp_diag_val, rsp_nondiag_val, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/yrow_read_extract.sv
// Fetches the Y-memory row(s) holding one diagonal and one non-diagonal entry and
// returns both 48-bit {real,img} values on a valid/ready response port.
module yrow_read_extract #(
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       ROW_W     = 256,
    parameter int unsigned       ENTRY_W   = 48,
    parameter int unsigned       SLOT_W    = 64,
    parameter int unsigned       MEM_LAT   = 1,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 11'h7ff
) (
    input logic           clock,
    input logic           reset,
    input logic           enable,
    yrow_read_extract_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_ISSUE2 = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] nondiag_addr;
    logic [3:0]        diag_oh;
    logic [3:0]        nondiag_oh;
    logic              same_row;
    // Bit k set: the tagged read was issued k+1 cycles ago; the top bit marks its capture cycle.
    logic [MEM_LAT-1:0] diag_sr;
    logic [MEM_LAT-1:0] nondiag_sr;
    logic               diag_cap;
    logic               nondiag_cap;

    function automatic logic [ENTRY_W-1:0] extract(input logic [ROW_W-1:0] row,
                                                   input logic [3:0] oh);
        case (oh)
            4'b0001: extract = row[0*SLOT_W +: ENTRY_W];
            4'b0010: extract = row[1*SLOT_W +: ENTRY_W];
            4'b0100: extract = row[2*SLOT_W +: ENTRY_W];
            4'b1000: extract = row[3*SLOT_W +: ENTRY_W];
            default: extract = '0;
        endcase
    endfunction

    function automatic logic oh_bad(input logic [3:0] oh);
        case (oh)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: oh_bad = 1'b0;
            default:                            oh_bad = 1'b1;
        endcase
    endfunction

    assign diag_cap    = diag_sr[MEM_LAT-1];
    assign nondiag_cap = nondiag_sr[MEM_LAT-1];

    always_ff @(posedge clock) begin
        if (!reset || !enable) begin
            state               <= S_IDLE;
            nondiag_addr        <= '0;
            diag_oh             <= '0;
            nondiag_oh          <= '0;
            same_row            <= 1'b0;
            diag_sr             <= '0;
            nondiag_sr          <= '0;
            bus.req_ready       <= 1'b0;
            bus.mem_rd_en       <= 1'b0;
            bus.mem_rd_addr     <= IDLE_ADDR;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_diag_val    <= '0;
            bus.rsp_nondiag_val <= '0;
            bus.rsp_err         <= 1'b0;
        end else begin
            diag_sr[0]    <= (state == S_ISSUE);
            nondiag_sr[0] <= (state == S_ISSUE2) || ((state == S_ISSUE) && same_row);
            for (int unsigned i = MEM_LAT - 1; i > 0; i--) begin
                diag_sr[i]    <= diag_sr[i-1];
                nondiag_sr[i] <= nondiag_sr[i-1];
            end

            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= IDLE_ADDR;

            // With a one-cycle memory the diag row returns while the second read is being issued.
            if (diag_cap) begin
                bus.rsp_diag_val <= extract(bus.mem_rd_data, diag_oh);
            end
            if (nondiag_cap) begin
                bus.rsp_nondiag_val <= extract(bus.mem_rd_data, nondiag_oh);
                bus.rsp_err         <= oh_bad(diag_oh) || oh_bad(nondiag_oh);
            end

            case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        nondiag_addr    <= bus.req_nondiag_addr;
                        diag_oh         <= bus.req_diag_oh;
                        nondiag_oh      <= bus.req_nondiag_oh;
                        same_row        <= (bus.req_diag_addr == bus.req_nondiag_addr);
                        bus.req_ready   <= 1'b0;
                        bus.mem_rd_en   <= 1'b1;
                        bus.mem_rd_addr <= bus.req_diag_addr;
                        state           <= S_ISSUE;
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (same_row) begin
                        state <= S_WAIT;
                    end else begin
                        bus.mem_rd_en   <= 1'b1;
                        bus.mem_rd_addr <= nondiag_addr;
                        state           <= S_ISSUE2;
                    end
                end
                S_ISSUE2: state <= S_WAIT;
                S_WAIT: begin
                    if (nondiag_cap) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_yrow_read_extract.sv
// Directed bench: two instances (MEM_LAT=1 and MEM_LAT=3) share the request stream,
// each behind its own Y-memory model that drives garbage outside return cycles.
module tb_yrow_read_extract;
    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b1;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic        req_valid        = 1'b0;
    logic [10:0] req_diag_addr    = '0;
    logic [10:0] req_nondiag_addr = '0;
    logic [3:0]  req_diag_oh      = '0;
    logic [3:0]  req_nondiag_oh   = '0;
    logic        rsp_ready        = 1'b1;

    yrow_read_extract_if b1 ();
    yrow_read_extract_if b3 ();

    yrow_read_extract #(.MEM_LAT(1)) dut1 (.clock(clock), .reset(reset), .enable(enable), .bus(b1));
    yrow_read_extract #(.MEM_LAT(3)) dut3 (.clock(clock), .reset(reset), .enable(enable), .bus(b3));

    assign b1.req_valid = req_valid;        assign b3.req_valid = req_valid;
    assign b1.req_diag_addr = req_diag_addr; assign b3.req_diag_addr = req_diag_addr;
    assign b1.req_nondiag_addr = req_nondiag_addr; assign b3.req_nondiag_addr = req_nondiag_addr;
    assign b1.req_diag_oh = req_diag_oh;    assign b3.req_diag_oh = req_diag_oh;
    assign b1.req_nondiag_oh = req_nondiag_oh; assign b3.req_nondiag_oh = req_nondiag_oh;
    assign b1.rsp_ready = rsp_ready;        assign b3.rsp_ready = rsp_ready;

    // Memory models: data valid only MEM_LAT cycles after the read strobe.
    logic [255:0] mem [0:2047];
    logic [255:0] garb = '0;
    logic         v1 = 1'b0;
    logic [10:0]  a1 = '0;
    logic [2:0]   v3 = '0;
    logic [10:0]  a3 [0:2];

    always @(posedge clock) begin
        garb  <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        v1    <= b1.mem_rd_en;
        a1    <= b1.mem_rd_addr;
        v3    <= {v3[1:0], b3.mem_rd_en};
        a3[0] <= b3.mem_rd_addr;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign b1.mem_rd_data = v1    ? mem[a1]    : garb;
    assign b3.mem_rd_data = v3[2] ? mem[a3[2]] : garb;

    logic        en [2];
    logic [10:0] addr [2];
    logic        rv [2];
    logic        rr [2];
    logic [47:0] dv [2];
    logic [47:0] nv [2];
    logic        er [2];
    assign en[0] = b1.mem_rd_en;       assign en[1] = b3.mem_rd_en;
    assign addr[0] = b1.mem_rd_addr;   assign addr[1] = b3.mem_rd_addr;
    assign rv[0] = b1.rsp_valid;       assign rv[1] = b3.rsp_valid;
    assign rr[0] = b1.req_ready;       assign rr[1] = b3.req_ready;
    assign dv[0] = b1.rsp_diag_val;    assign dv[1] = b3.rsp_diag_val;
    assign nv[0] = b1.rsp_nondiag_val; assign nv[1] = b3.rsp_nondiag_val;
    assign er[0] = b1.rsp_err;         assign er[1] = b3.rsp_err;

    int          rd_cnt [2];
    logic [10:0] rd_addr [2][2];
    int          rd_rel [2][2];
    int          rsp_rel [2];
    logic [47:0] got_d [2];
    logic [47:0] got_n [2];
    logic        got_e [2];

    function automatic logic [255:0] mkrow(input logic [47:0] s3, s2, s1, s0);
        return {16'hDEAD, s3, 16'hBEEF, s2, 16'hDEAD, s1, 16'hBEEF, s0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [10:0] da, na, input logic [3:0] doh, noh);
        int n = 0;
        while (!(rr[0] && rr[1]) && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_before_accept", {rr[0], rr[1]}, 2'b11);
        req_valid = 1'b1;
        req_diag_addr = da; req_nondiag_addr = na;
        req_diag_oh = doh;  req_nondiag_oh = noh;
        tick();
        // Scramble request inputs: they must be ignored after the accept edge.
        req_valid = 1'b0;
        req_diag_addr = 11'h2AA; req_nondiag_addr = 11'h155;
        req_diag_oh = 4'b0001;   req_nondiag_oh = 4'b1000;
    endtask

    task automatic monitor(input int cycles);
        for (int d = 0; d < 2; d++) begin
            rd_cnt[d] = 0; rsp_rel[d] = 0;
        end
        for (int rel = 1; rel <= cycles; rel++) begin
            for (int d = 0; d < 2; d++) begin
                if (en[d]) begin
                    if (rd_cnt[d] < 2) begin
                        rd_addr[d][rd_cnt[d]] = addr[d];
                        rd_rel[d][rd_cnt[d]]  = rel;
                    end
                    rd_cnt[d]++;
                end
                if (rv[d] && rsp_rel[d] == 0) begin
                    rsp_rel[d] = rel;
                    got_d[d] = dv[d]; got_n[d] = nv[d]; got_e[d] = er[d];
                end
            end
            tick();
        end
    endtask

    task automatic verify(input string name, input int d, input int nrd,
                          input logic [10:0] a0, a1x, input int rel,
                          input logic [47:0] exp_d, exp_n, input logic exp_e);
        string p;
        p = $sformatf("%s/lat%0d", name, d == 0 ? 1 : 3);
        check({p, "_reads"}, rd_cnt[d], nrd);
        check({p, "_rd0_addr"}, rd_addr[d][0], a0);
        check({p, "_rd0_cycle"}, rd_rel[d][0], 1);
        if (nrd == 2) begin
            check({p, "_rd1_addr"}, rd_addr[d][1], a1x);
            check({p, "_rd1_cycle"}, rd_rel[d][1], 2);
        end
        check({p, "_rsp_cycle"}, rsp_rel[d], rel);
        check({p, "_diag"}, got_d[d], exp_d);
        check({p, "_nondiag"}, got_n[d], exp_n);
        check({p, "_err"}, got_e[d], exp_e);
    endtask

    task automatic check_reset_outputs(input string name);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s%0d_req_ready", name, d), rr[d], 1'b0);
            check($sformatf("%s%0d_rd_en", name, d), en[d], 1'b0);
            check($sformatf("%s%0d_rd_addr", name, d), addr[d], 11'h7ff);
            check($sformatf("%s%0d_rsp_valid", name, d), rv[d], 1'b0);
            check($sformatf("%s%0d_diag", name, d), dv[d], 48'h0);
            check($sformatf("%s%0d_nondiag", name, d), nv[d], 48'h0);
            check($sformatf("%s%0d_err", name, d), er[d], 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[11'h010] = mkrow(48'h555555_666666, 48'h111111_222222, 48'h333333_444444, 48'hAAAAAA_BBBBBB);
        mem[11'h005] = mkrow(48'h123456_789ABC, 48'h777777_888888, 48'hCAFE00_00BEEF, 48'h0F0F0F_F0F0F0);
        mem[11'h3FF] = mkrow(48'h999999_000000, 48'hA5A5A5_5A5A5A, 48'hFEDCBA_987654, 48'h010203_040506);

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        check("req_ready_still_low", {rr[0], rr[1]}, 2'b00);
        tick();
        check("req_ready_after_reset", {rr[0], rr[1]}, 2'b11);

        accept(11'h010, 11'h010, 4'b0001, 4'b0100);
        monitor(12);
        verify("same_row", 0, 1, 11'h010, 11'h0, 3, 48'hAAAAAA_BBBBBB, 48'h111111_222222, 1'b0);
        verify("same_row", 1, 1, 11'h010, 11'h0, 5, 48'hAAAAAA_BBBBBB, 48'h111111_222222, 1'b0);

        accept(11'h005, 11'h3FF, 4'b1000, 4'b0010);
        monitor(12);
        verify("two_rows", 0, 2, 11'h005, 11'h3FF, 4, 48'h123456_789ABC, 48'hFEDCBA_987654, 1'b0);
        verify("two_rows", 1, 2, 11'h005, 11'h3FF, 6, 48'h123456_789ABC, 48'hFEDCBA_987654, 1'b0);

        accept(11'h005, 11'h3FF, 4'b0110, 4'b0001);
        monitor(12);
        verify("bad_diag_oh", 0, 2, 11'h005, 11'h3FF, 4, 48'h0, 48'h010203_040506, 1'b1);
        verify("bad_diag_oh", 1, 2, 11'h005, 11'h3FF, 6, 48'h0, 48'h010203_040506, 1'b1);

        accept(11'h010, 11'h010, 4'b0010, 4'b0000);
        monitor(12);
        verify("zero_nd_oh", 0, 1, 11'h010, 11'h0, 3, 48'h333333_444444, 48'h0, 1'b1);
        verify("zero_nd_oh", 1, 1, 11'h010, 11'h0, 5, 48'h333333_444444, 48'h0, 1'b1);

        accept(11'h3FF, 11'h3FF, 4'b0100, 4'b0100);
        monitor(12);
        verify("same_slot", 0, 1, 11'h3FF, 11'h0, 3, 48'hA5A5A5_5A5A5A, 48'hA5A5A5_5A5A5A, 1'b0);
        verify("same_slot", 1, 1, 11'h3FF, 11'h0, 5, 48'hA5A5A5_5A5A5A, 48'hA5A5A5_5A5A5A, 1'b0);

        // Backpressure: hold the response while a new request is offered.
        rsp_ready = 1'b0;
        accept(11'h010, 11'h010, 4'b1000, 4'b0010);
        n = 0;
        while (!(rv[0] && rv[1]) && n < 20) begin
            tick();
            n++;
        end
        check("bp_rsp_valid", {rv[0], rv[1]}, 2'b11);
        req_valid = 1'b1;
        req_diag_addr = 11'h005; req_nondiag_addr = 11'h3FF;
        req_diag_oh = 4'b0001;   req_nondiag_oh = 4'b0001;
        repeat (5) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("bp%0d_valid", d), rv[d], 1'b1);
                check($sformatf("bp%0d_diag", d), dv[d], 48'h555555_666666);
                check($sformatf("bp%0d_nondiag", d), nv[d], 48'h333333_444444);
                check($sformatf("bp%0d_err", d), er[d], 1'b0);
                check($sformatf("bp%0d_req_ready", d), rr[d], 1'b0);
                check($sformatf("bp%0d_no_read", d), en[d], 1'b0);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", {rv[0], rv[1]}, 2'b00);
        check("bp_release_ready_gap", {rr[0], rr[1]}, 2'b00);
        tick();
        check("bp_ready_back", {rr[0], rr[1]}, 2'b11);

        // Abort a two-row request during WAIT, first via enable, then via reset.
        for (int k = 0; k < 2; k++) begin
            accept(11'h005, 11'h3FF, 4'b1000, 4'b0010);
            tick();
            tick();
            if (k == 0) enable = 1'b0;
            else        reset  = 1'b0;
            tick();
            check_reset_outputs(k == 0 ? "en_abort" : "rst_abort");
            enable = 1'b1;
            reset  = 1'b1;
            monitor(10);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("abort%0d_%0d_no_rsp", k, d), rsp_rel[d], 0);
                check($sformatf("abort%0d_%0d_no_read", k, d), rd_cnt[d], 0);
            end
            accept(11'h3FF, 11'h005, 4'b0001, 4'b1000);
            monitor(12);
            verify("after_abort", 0, 2, 11'h3FF, 11'h005, 4, 48'h010203_040506, 48'h123456_789ABC, 1'b0);
            verify("after_abort", 1, 2, 11'h3FF, 11'h005, 6, 48'h010203_040506, 48'h123456_789ABC, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/yrow_read_extract.md
Name: yrow_read_extract

Overview:
- Read-side counterpart of the Y-memory write-back path.
- Accepts a request for one diagonal and one non-diagonal Y entry, each given as a row address plus a 4-bit one-hot slot select.
- Fetches the needed 256-bit row(s) from Y memory, with one read when both entries share a row and two back-to-back reads otherwise.
- Returns both 48-bit {real,img} values on a valid/ready response port.
- Sits between the Y memory read port and the diagonal compute datapath.

Parameters:
ADDR_W, 11, row address width
ROW_W, 256, Y memory row width
ENTRY_W, 48, entry width ({real[47:24], img[23:0]})
SLOT_W, 64, slot pitch inside a row (4 slots per row)
MEM_LAT, 1, Y memory read latency in cycles (legal 1..4)
IDLE_ADDR, 11'h7ff, value driven on mem_rd_addr when no read is issued

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset
enable  in  1  module enable; low behaves exactly as reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_diag_addr  in  ADDR_W  row holding diagonal entry
req_nondiag_addr  in  ADDR_W  row holding non-diagonal entry
req_diag_oh  in  4  one-hot slot of diagonal entry
req_nondiag_oh  in  4  one-hot slot of non-diagonal entry
mem_rd_en  out  1  Y memory read strobe
mem_rd_addr  out  ADDR_W  Y memory read address
mem_rd_data  in  ROW_W  Y memory read data
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_diag_val  out  ENTRY_W  extracted diagonal entry
rsp_nondiag_val  out  ENTRY_W  extracted non-diagonal entry
rsp_err  out  1  a one-hot select was not exactly one bit

Behaviour:
- Reset: already decided; reset is synchronous and active-low on clock. Reset, or enable low, sampled at a rising edge does the following:
  - req_ready=0, mem_rd_en=0, mem_rd_addr=IDLE_ADDR, rsp_valid=0, rsp_diag_val=0, rsp_nondiag_val=0, rsp_err=0.
  - State goes to IDLE and any in-flight request is discarded.
  - req_ready rises the first cycle after reset and enable are both high.
- All outputs are registered.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch all request fields, set same_row=(diag_addr==nondiag_addr), go to ISSUE. req_ready=0 in every other state.
  - ISSUE: mem_rd_en=1, mem_rd_addr=diag_addr. If same_row, go to WAIT. Otherwise go to ISSUE2.
  - ISSUE2: mem_rd_en=1, mem_rd_addr=nondiag_addr, go to WAIT.
  - WAIT: mem_rd_en=0, mem_rd_addr=IDLE_ADDR. The latency counter tracks the last issued read. Data for a read issued in cycle A is valid on mem_rd_data during cycle A+MEM_LAT and is sampled at the end of that cycle.
    - The diagonal extract is captured from the diag read's return cycle. The non-diagonal extract comes from the same row if same_row, otherwise from the second read's return cycle.
    - After the last capture, go to RESP.
  - RESP: rsp_valid=1 and all rsp_* held stable until rsp_ready=1 at an edge. Then go to IDLE: rsp_valid=0, and req_ready=1 the next cycle.
- Latency, accept edge at end of cycle T:
  - Same row: single read in T+1, rsp_valid from T+2+MEM_LAT.
  - Different rows: reads in T+1 and T+2, rsp_valid from T+3+MEM_LAT.
- Extraction, per one-hot:
  - 0001 → row[47:0]
  - 0010 → row[111:64]
  - 0100 → row[175:128]
  - 1000 → row[239:192]
  - Padding bits (row[63:48], etc.) are ignored. Values pass through unmodified; no sign handling.
- Invalid one-hot (zero bits or more than one bit set): that value = 0, rsp_err=1. The memory read is still performed and the response is still delivered.
- Same row with identical one-hot: both values equal the same slot, and rsp_err=0.
- Request inputs are ignored outside the IDLE accept cycle. Changing them mid-operation has no effect.
- mem_rd_data is ignored in every cycle not designated as a capture cycle.
- No back-to-back acceptance: at least one IDLE cycle separates consecutive responses.

Test Plan:
- Same row, MEM_LAT=1: diag 0x010/0001, nondiag 0x010/0100, row with [47:0]=48'hAAAAAA_BBBBBB and [175:128]=48'h111111_222222 → exactly one mem_rd_en pulse (addr 0x010) in T+1; rsp_valid in T+3 with those two values; rsp_err=0.
- Different rows: diag 0x005/1000, nondiag 0x3FF/0010 → reads at 0x005 then 0x3FF on consecutive cycles; diag=row5[239:192], nondiag=row0x3FF[111:64]; rsp_valid in T+4.
- Backpressure: rsp_ready held 0 for 5 cycles → rsp_* stable, req_ready=0, and a new req_valid is not accepted. rsp_ready=1 → IDLE, and req_ready=1 one cycle later.
- Invalid one-hot: diag_oh=0110 → rsp_diag_val=0, rsp_err=1, nondiag value correct.
- Reset or enable drop during WAIT of a two-row request → all outputs return to reset values at the next edge, no response is produced, and a fresh request afterwards completes normally.
- MEM_LAT=3, different rows: mem_rd_data driven with garbage on non-capture cycles → correct values captured, rsp_valid at T+6.
